// File: rtl/inst_fetch_axi.sv
// Instruction-fetch AXI4 read master: one single-beat read per fetch, result
// held for the IF/ID stage on a valid/ready handshake, flushed fetches drained.
module inst_fetch_axi (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        pc_valid,
  output logic        pc_ready,
  input  logic [31:0] pc_excepttype,
  input  logic        flush,
  input  logic        full,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic [31:0] if_excepttype,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  localparam logic [31:0] EXC_MISALIGN = 32'h0000_4000;
  localparam logic [31:0] EXC_BUS      = 32'h0000_2000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_HOLD,
    S_DRAIN
  } state_t;

  state_t      state, state_nx;
  logic        cancel, cancel_nx;
  logic [31:0] exc_lat;
  logic        accept;
  logic        misaligned;
  logic        capture;

  // The slave always returns rid 0 with rlast set on the single beat.
  logic unused;
  assign unused = ^{rid, rlast, rresp[0]};

  assign arid    = 4'd0;
  assign arlen   = 8'd0;
  assign arsize  = 3'b010;
  assign arburst = 2'b01;

  assign misaligned = (pc[1:0] != 2'b00);
  assign accept     = pc_valid & pc_ready;
  assign capture    = (state == S_DATA) & rvalid & ~flush;

  // NOTE: every signal driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_nx   = state;
    cancel_nx  = cancel;
    pc_ready   = 1'b0;
    arvalid    = 1'b0;
    rready     = 1'b0;
    inst_valid = 1'b0;

    unique case (state)
      S_IDLE: begin
        pc_ready = rst & ~full & ~flush;
        if (accept) state_nx = misaligned ? S_HOLD : S_ADDR;
      end
      S_ADDR: begin
        // A flush cannot withdraw arvalid; remember it until the address goes out.
        arvalid = 1'b1;
        if (flush) cancel_nx = 1'b1;
        if (arready) begin
          state_nx  = (cancel | flush) ? S_DRAIN : S_DATA;
          cancel_nx = 1'b0;
        end
      end
      S_DATA: begin
        rready = 1'b1;
        if (rvalid)     state_nx = flush ? S_IDLE : S_HOLD;
        else if (flush) state_nx = S_DRAIN;
      end
      S_HOLD: begin
        inst_valid = 1'b1;
        pc_ready   = rst & inst_ready & ~full & ~flush;
        if (flush)           state_nx = S_IDLE;
        else if (accept)     state_nx = misaligned ? S_HOLD : S_ADDR;
        else if (inst_ready) state_nx = S_IDLE;
      end
      S_DRAIN: begin
        rready = 1'b1;
        if (rvalid) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= S_IDLE;
      cancel        <= 1'b0;
      araddr        <= 32'd0;
      if_pc         <= 32'd0;
      if_inst       <= 32'd0;
      if_excepttype <= 32'd0;
      exc_lat       <= 32'd0;
    end else begin
      state  <= state_nx;
      cancel <= cancel_nx;
      if (accept) begin
        araddr  <= pc;
        if_pc   <= pc;
        exc_lat <= pc_excepttype;
        if (misaligned) begin
          if_inst       <= 32'd0;
          if_excepttype <= pc_excepttype | EXC_MISALIGN;
        end
      end
      if (capture) begin
        if_inst       <= rresp[1] ? 32'd0 : rdata;
        if_excepttype <= exc_lat | (rresp[1] ? EXC_BUS : 32'd0);
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_axi.sv
// Self-checking bench for inst_fetch_axi: directed scenarios plus a randomized
// run against a queue-based fetch model and a behavioural AXI slave.
module tb_inst_fetch_axi;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc = '0, pc_excepttype = '0;
  logic        pc_valid = 1'b0, flush = 1'b0, full = 1'b0, inst_ready = 1'b0;
  logic        pc_ready;
  logic [31:0] if_pc, if_inst, if_excepttype;
  logic        inst_valid;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [3:0]  rid = 4'd0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = 2'b00;
  logic        rlast = 1'b1;
  logic        rvalid = 1'b0;
  logic        rready;

  inst_fetch_axi dut (
    .clk(clk), .rst(rst), .pc(pc), .pc_valid(pc_valid), .pc_ready(pc_ready),
    .pc_excepttype(pc_excepttype), .flush(flush), .full(full),
    .if_pc(if_pc), .if_inst(if_inst), .if_excepttype(if_excepttype),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] exc;
  } fetch_t;

  fetch_t exp_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic bit bus_err(input logic [31:0] a);
    return a[6:4] == 3'b111;
  endfunction

  function automatic fetch_t expect_fetch(input logic [31:0] a, input logic [31:0] e);
    fetch_t f;
    f.pc = a;
    if (a[1:0] != 2'b00) begin
      f.inst = 32'd0;
      f.exc  = e | 32'h0000_4000;
    end else if (bus_err(a)) begin
      f.inst = 32'd0;
      f.exc  = e | 32'h0000_2000;
    end else begin
      f.inst = mem_word(a);
      f.exc  = e;
    end
    return f;
  endfunction

  // Slave configuration: wait cycles before arready / rvalid, response mode
  // (0 OKAY, 1 SLVERR, 2 error by address hash), optional fixed data word.
  int          ar_min = 0, ar_max = 0, r_min = 0, r_max = 0;
  int          resp_mode = 0;
  bit          data_ovr_en = 1'b0;
  logic [31:0] data_ovr = '0;

  bit          pend = 1'b0, ar_armed = 1'b0;
  logic [31:0] pend_addr = '0;
  int          ar_wait = 0, r_wait = 0;

  bit          ar_hs = 1'b0, r_hs = 1'b0, stall_prev = 1'b0;
  logic [31:0] ar_hs_addr = '0, stall_addr = '0;
  int          ar_count = 0, r_count = 0, deliver_count = 0;

  always @(posedge clk) begin
    ar_hs      <= rst && arvalid && arready;
    r_hs       <= rst && rvalid && rready;
    ar_hs_addr <= araddr;
    if (rst) begin
      if (arvalid && arready)      ar_count      <= ar_count + 1;
      if (rvalid && rready)        r_count       <= r_count + 1;
      if (inst_valid && inst_ready) deliver_count <= deliver_count + 1;
      if (stall_prev) begin
        checks++;
        if (arvalid !== 1'b1 || araddr !== stall_addr)
          $display("FAIL ar_stable: arvalid=%b araddr=%h, required arvalid=1 araddr=%h",
                   arvalid, araddr, stall_addr);
        else passes++;
      end
      if (arvalid) begin
        checks++;
        if (pend) $display("FAIL one_outstanding: arvalid=1 while a read is outstanding, required 0");
        else passes++;
      end
    end
    stall_prev <= rst && arvalid && !arready;
    stall_addr <= araddr;
  end

  always @(negedge clk) begin
    if (!rst) begin
      arready = 1'b0; rvalid = 1'b0; rresp = 2'b00; pend = 1'b0; ar_armed = 1'b0;
    end else begin
      if (r_hs) begin
        rvalid = 1'b0;
        pend   = 1'b0;
      end
      if (ar_hs) begin
        arready   = 1'b0;
        ar_armed  = 1'b0;
        pend      = 1'b1;
        pend_addr = ar_hs_addr;
        r_wait    = $urandom_range(r_max, r_min);
      end
      if (pend && !rvalid) begin
        if (r_wait == 0) begin
          rvalid = 1'b1;
          rdata  = data_ovr_en ? data_ovr : mem_word(pend_addr);
          rresp  = (resp_mode == 1 || (resp_mode == 2 && bus_err(pend_addr))) ? 2'b10 : 2'b00;
        end else r_wait--;
      end
      if (arvalid && !pend && !arready) begin
        if (!ar_armed) begin
          ar_wait  = $urandom_range(ar_max, ar_min);
          ar_armed = 1'b1;
        end
        if (ar_wait == 0) arready = 1'b1;
        else ar_wait--;
      end
    end
  end

  // Presents a fetch request and waits for its accept; returns at the
  // falling edge right after the accepting clock edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] e);
    bit ok = 1'b0;
    @(negedge clk);
    pc = a; pc_excepttype = e; pc_valid = 1'b1;
    #1;
    for (int n = 0; n < 40 && !ok; n++) begin
      if (pc_ready) ok = 1'b1;
      else begin
        @(negedge clk);
        #1;
      end
    end
    if (!ok) begin
      checks++;
      $display("FAIL issue_timeout: pc_ready stayed 0 for pc=%h, required 1", a);
    end
    @(negedge clk);
    pc_valid = 1'b0;
  endtask

  task automatic wait_valid(output int k);
    k = 0;
    while (!inst_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!inst_valid) begin
      checks++;
      $display("FAIL wait_valid: inst_valid=0 after %0d cycles, required 1", k);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    checks++;
    if ({pc_ready, arvalid, rready, inst_valid, araddr, if_pc, if_inst, if_excepttype} !== '0)
      $display("FAIL reset_outputs: pc_ready=%b arvalid=%b rready=%b inst_valid=%b araddr=%h if_pc=%h if_inst=%h if_exc=%h, required all 0",
               pc_ready, arvalid, rready, inst_valid, araddr, if_pc, if_inst, if_excepttype);
    else passes++;
    checks++;
    if ({arid, arlen, arsize, arburst} !== {4'd0, 8'd0, 3'b010, 2'b01})
      $display("FAIL ar_constants: arid=%h arlen=%h arsize=%b arburst=%b, required 0 0 010 01",
               arid, arlen, arsize, arburst);
    else passes++;
  endtask

  task automatic test_aligned();
    int k;
    ar_min = 0; ar_max = 0; r_min = 0; r_max = 0; resp_mode = 0;
    data_ovr_en = 1'b1; data_ovr = 32'h3C08_0001;
    inst_ready = 1'b1;
    issue(32'hBFC0_0000, 32'd0);
    checks++;
    if (arvalid !== 1'b1 || araddr !== 32'hBFC0_0000 || arlen !== 8'd0 || arsize !== 3'd2)
      $display("FAIL aligned_ar: arvalid=%b araddr=%h arlen=%h arsize=%h, required 1 bfc00000 00 2",
               arvalid, araddr, arlen, arsize);
    else passes++;
    wait_valid(k);
    checks++;
    if (k + 1 != 3) $display("FAIL aligned_latency: %0d cycles, required 3", k + 1);
    else passes++;
    checks++;
    if ({if_pc, if_inst, if_excepttype} !== {32'hBFC0_0000, 32'h3C08_0001, 32'd0})
      $display("FAIL aligned_data: pc=%h inst=%h exc=%h, required bfc00000 3c080001 00000000",
               if_pc, if_inst, if_excepttype);
    else passes++;
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b0) $display("FAIL aligned_done: inst_valid=%b, required 0", inst_valid);
    else passes++;
    data_ovr_en = 1'b0;
  endtask

  task automatic test_backpressure();
    int k, a0, d0;
    logic [95:0] held;
    bit bad = 1'b0;
    ar_min = 0; ar_max = 2; r_min = 0; r_max = 2; resp_mode = 0;
    inst_ready = 1'b0;
    issue(32'h0040_0100, 32'h0000_0008);
    wait_valid(k);
    held = {if_pc, if_inst, if_excepttype};
    checks++;
    if (held !== {32'h0040_0100, mem_word(32'h0040_0100), 32'h0000_0008})
      $display("FAIL bp_data: pc=%h inst=%h exc=%h, required 00400100 %h 00000008",
               if_pc, if_inst, if_excepttype, mem_word(32'h0040_0100));
    else passes++;
    a0 = ar_count;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pc_valid = 1'b1; pc = 32'h0040_0200;
      #1;
      if (inst_valid !== 1'b1 || {if_pc, if_inst, if_excepttype} !== held ||
          pc_ready !== 1'b0 || arvalid !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad || ar_count != a0)
      $display("FAIL bp_hold: stall violated (bad=%0d new_ar=%0d), required stable and 0 new reads",
               bad, ar_count - a0);
    else passes++;
    d0 = deliver_count;
    pc_valid = 1'b0; inst_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (deliver_count - d0 != 1 || inst_valid !== 1'b0)
      $display("FAIL bp_release: transfers=%0d inst_valid=%b, required 1 and 0",
               deliver_count - d0, inst_valid);
    else passes++;
  endtask

  task automatic test_flush_addr();
    int a0, r0, d0, arv_cycles = 0;
    bit saw_valid = 1'b0;
    ar_min = 3; ar_max = 3; r_min = 0; r_max = 0; resp_mode = 0;
    data_ovr_en = 1'b1; data_ovr = 32'hDEAD_BEEF;
    inst_ready = 1'b1;
    a0 = ar_count; r0 = r_count; d0 = deliver_count;
    issue(32'h0000_1000, 32'd0);
    flush = 1'b1;
    for (int n = 0; n < 15; n++) begin
      if (arvalid) arv_cycles++;
      if (inst_valid) saw_valid = 1'b1;
      @(negedge clk);
      flush = 1'b0;
    end
    #1;
    // Three wait cycles in the slave keep arvalid visible for four cycles.
    checks++;
    if (arv_cycles != 4) $display("FAIL flush_arvalid: high %0d cycles, required 4", arv_cycles);
    else passes++;
    checks++;
    if (ar_count - a0 != 1 || r_count - r0 != 1)
      $display("FAIL flush_drain: ar=%0d r=%0d, required 1 1", ar_count - a0, r_count - r0);
    else passes++;
    checks++;
    if (saw_valid || deliver_count != d0)
      $display("FAIL flush_discard: inst_valid seen=%0d transfers=%0d, required 0 0",
               saw_valid, deliver_count - d0);
    else passes++;
    checks++;
    if (pc_ready !== 1'b1 || rready !== 1'b0)
      $display("FAIL flush_idle: pc_ready=%b rready=%b, required 1 0", pc_ready, rready);
    else passes++;
    data_ovr_en = 1'b0;
  endtask

  task automatic test_misaligned();
    int a0;
    inst_ready = 1'b1;
    a0 = ar_count;
    issue(32'h8000_0002, 32'd0);
    checks++;
    if (inst_valid !== 1'b1 || arvalid !== 1'b0 ||
        {if_pc, if_inst, if_excepttype} !== {32'h8000_0002, 32'd0, 32'h0000_4000})
      $display("FAIL misaligned: valid=%b arvalid=%b pc=%h inst=%h exc=%h, required 1 0 80000002 0 00004000",
               inst_valid, arvalid, if_pc, if_inst, if_excepttype);
    else passes++;
    @(negedge clk);
    checks++;
    if (ar_count != a0 || inst_valid !== 1'b0)
      $display("FAIL misaligned_noaxi: reads=%0d inst_valid=%b, required 0 0", ar_count - a0, inst_valid);
    else passes++;
  endtask

  task automatic test_bus_error();
    int k;
    ar_min = 1; ar_max = 2; r_min = 1; r_max = 2; resp_mode = 1;
    inst_ready = 1'b1;
    issue(32'h0000_2000, 32'd0);
    wait_valid(k);
    checks++;
    if (if_inst !== 32'd0 || if_excepttype !== 32'h0000_2000)
      $display("FAIL bus_error: inst=%h exc=%h, required 0 00002000", if_inst, if_excepttype);
    else passes++;
    @(negedge clk);
    resp_mode = 0;
  endtask

  task automatic test_full_reset();
    int a0, k;
    bit bad = 1'b0, in_data = 1'b0;
    a0 = ar_count;
    full = 1'b1; pc_valid = 1'b1; pc = 32'h0000_0100;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      if (pc_ready !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad || ar_count != a0)
      $display("FAIL full_block: pc_ready high=%0d reads=%0d, required 0 0", bad, ar_count - a0);
    else passes++;
    full = 1'b0; pc_valid = 1'b0;
    ar_min = 0; ar_max = 0; r_min = 6; r_max = 6;
    issue(32'h0000_0300, 32'd0);
    for (int n = 0; n < 20 && !in_data; n++) begin
      if (rready) in_data = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!in_data) $display("FAIL reach_data: rready=0, required 1");
    else passes++;
    rst = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({pc_ready, arvalid, rready, inst_valid, arid, arlen, araddr, if_pc, if_inst, if_excepttype} !== '0)
      $display("FAIL reset_mid: pc_ready=%b arvalid=%b rready=%b inst_valid=%b araddr=%h if_pc=%h if_inst=%h if_exc=%h, required all 0",
               pc_ready, arvalid, rready, inst_valid, araddr, if_pc, if_inst, if_excepttype);
    else passes++;
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (pc_ready !== 1'b1 || arvalid !== 1'b0 || inst_valid !== 1'b0)
      $display("FAIL reset_idle: pc_ready=%b arvalid=%b inst_valid=%b, required 1 0 0",
               pc_ready, arvalid, inst_valid);
    else passes++;
    r_min = 0; r_max = 2;
    inst_ready = 1'b1;
    issue(32'h0000_0400, 32'h0000_0001);
    wait_valid(k);
    checks++;
    if ({if_pc, if_inst, if_excepttype} !== {32'h0000_0400, mem_word(32'h0000_0400), 32'h0000_0001})
      $display("FAIL after_reset: pc=%h inst=%h exc=%h, required 00000400 %h 00000001",
               if_pc, if_inst, if_excepttype, mem_word(32'h0000_0400));
    else passes++;
    @(negedge clk);
  endtask

  bit          hold_prev = 1'b0;
  logic [95:0] held_word = '0;
  int          rand_delivered = 0;

  task automatic model_step();
    fetch_t e;
    if (hold_prev) begin
      checks++;
      if (inst_valid !== 1'b1 || {if_pc, if_inst, if_excepttype} !== held_word)
        $display("FAIL rand_stable: valid=%b word=%h, required 1 %h",
                 inst_valid, {if_pc, if_inst, if_excepttype}, held_word);
      else passes++;
    end
    hold_prev = inst_valid && !inst_ready && !flush;
    held_word = {if_pc, if_inst, if_excepttype};
    if (full || flush) begin
      checks++;
      if (pc_ready !== 1'b0) $display("FAIL rand_ready_block: pc_ready=%b, required 0", pc_ready);
      else passes++;
    end else if (inst_valid) begin
      checks++;
      if (pc_ready !== inst_ready)
        $display("FAIL rand_ready_hold: pc_ready=%b, required %b", pc_ready, inst_ready);
      else passes++;
    end
    if (flush) exp_q.delete();
    else if (inst_valid && inst_ready) begin
      checks++;
      rand_delivered++;
      if (exp_q.size() == 0)
        $display("FAIL rand_unexpected: delivered pc=%h, required no delivery", if_pc);
      else begin
        e = exp_q.pop_front();
        if ({if_pc, if_inst, if_excepttype} !== e)
          $display("FAIL rand_data: pc=%h inst=%h exc=%h, required %h %h %h",
                   if_pc, if_inst, if_excepttype, e.pc, e.inst, e.exc);
        else passes++;
      end
    end
    if (pc_valid && pc_ready) exp_q.push_back(expect_fetch(pc, pc_excepttype));
  endtask

  task automatic test_random();
    ar_min = 0; ar_max = 3; r_min = 0; r_max = 3; resp_mode = 2; data_ovr_en = 1'b0;
    exp_q.delete();
    hold_prev = 1'b0;
    rand_delivered = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      pc_valid = ($urandom_range(9, 0) < 7);
      pc = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(7, 0) == 0) pc[1:0] = 2'($urandom_range(3, 1));
      pc_excepttype = $urandom & 32'h8000_00FF;
      full = ($urandom_range(9, 0) == 0);
      flush = ($urandom_range(31, 0) == 0);
      inst_ready = !flush && ($urandom_range(9, 0) < 6);
      #1;
      model_step();
    end
    for (int n = 0; n < 60 && exp_q.size() != 0; n++) begin
      @(negedge clk);
      pc_valid = 1'b0; full = 1'b0; flush = 1'b0; inst_ready = 1'b1;
      #1;
      model_step();
    end
    checks++;
    if (exp_q.size() != 0 || rand_delivered < 100)
      $display("FAIL rand_drain: pending=%0d delivered=%0d, required 0 and at least 100",
               exp_q.size(), rand_delivered);
    else passes++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    @(negedge clk);
    rst = 1'b1;
    test_aligned();
    test_backpressure();
    test_flush_addr();
    test_misaligned();
    test_bus_error();
    test_full_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/inst_fetch_axi.md
# inst_fetch_axi

Instruction-fetch AXI read master: accepts fetch addresses from the PC stage, issues single-beat AXI4 read bursts, and presents the returned instruction to the IF/ID pipeline register with a valid/ready handshake. It is the producing end of the `inst_valid`/`inst_ready` interface that IF/ID consumes. It discards responses belonging to flushed fetches and flags misaligned fetch addresses and bus errors in the exception word.

## Interface
- No parameters; bus widths fixed: 32-bit address, 32-bit data, 4-bit ID.
- `clk` in 1: single clock. Everything is sampled on the rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `pc` in 32: fetch address.
- `pc_valid` in 1: `pc` is a fetch request.
- `pc_ready` out 1: request accepted this cycle when `pc_valid & pc_ready`.
- `pc_excepttype` in 32: exception bits carried with `pc`.
- `flush` in 1: cancels the pending fetch and any held instruction.
- `full` in 1: IF/ID skid buffer is occupied; no new fetch is accepted.
- `if_pc` out 32: address of the delivered instruction.
- `if_inst` out 32: delivered instruction.
- `if_excepttype` out 32: exception bits of the delivered instruction.
- `inst_valid` out 1: `if_*` is valid.
- `inst_ready` in 1: consumer takes `if_*` when `inst_valid & inst_ready`.
- AR channel:
  - `arid` out 4: constant 0.
  - `araddr` out 32.
  - `arlen` out 8: constant 0.
  - `arsize` out 3: constant 3'b010.
  - `arburst` out 2: constant 2'b01.
  - `arvalid` out 1.
  - `arready` in 1.
- R channel:
  - `rid` in 4.
  - `rdata` in 32.
  - `rresp` in 2.
  - `rlast` in 1.
  - `rvalid` in 1.
  - `rready` out 1.

## Operation
- **States**
  - IDLE: no fetch in progress.
  - ADDR: `arvalid` high.
  - DATA: `rready` high.
  - HOLD: `inst_valid` high.
  - DRAIN: a cancelled transaction is completing.
- **`pc_ready`** = (IDLE | (HOLD & `inst_ready`)) & !`full` & !`flush`.
- **IDLE / HOLD on accept** (`pc_valid & pc_ready`)
  - Latch `pc` into `araddr` and `if_pc`.
  - Latch `pc_excepttype` into an internal register.
  - If `pc[1:0]` == 0: go to ADDR.
  - If `pc[1:0]` != 0: issue no AXI request; `if_inst` = 0; `if_excepttype` = `pc_excepttype | 32'h0000_4000`; go to HOLD.
- **HOLD**
  - Handshake (`inst_valid & inst_ready`) with no new accept: go to IDLE.
  - Handshake with a new accept: go to ADDR (or HOLD if misaligned).
- **ADDR**
  - `arvalid` stays high until `arready`; `araddr` is stable throughout.
  - On `arready`: go to DATA.
- **DATA**
  - On `rvalid` (`rlast` = 1, `rid` = 0 required): capture the beat.
  - `if_inst` = `rdata` if `rresp[1]` == 0, else 0.
  - `if_excepttype` = latched bits `| (rresp[1] ? 32'h0000_2000 : 0)`.
  - Go to HOLD.
- **flush**
  - IDLE: no effect.
  - HOLD: drop `inst_valid`; go to IDLE.
  - ADDR: `arvalid` is held until `arready` (AXI rule), then go to DRAIN.
  - DATA, no `rvalid` same cycle: go to DRAIN.
  - DATA with `rvalid` same cycle: the beat is consumed and discarded; go to IDLE.
- **DRAIN**
  - `rready` = 1; accept and discard the single beat; go to IDLE.
  - `flush` while in DRAIN: no further effect.
- **Outstanding reads**: at most one AXI read is outstanding at any time.

## Timing
- **Reset**: all outputs 0, state IDLE. Reset mid-transaction abandons it; the interconnect shares the same reset.
- **Latency**: accept at edge N → `arvalid` from N+1.
- **AR handshake**: `arready` at edge M → `rready` from M+1.
- **R beat**: `rvalid` at edge K → `inst_valid` from K+1.
- **Zero-wait slave**: 3 cycles from accept to `inst_valid`.
- **Misaligned fetch**: accept at N → `inst_valid` at N+1.
- **`rready`**: high only in DATA and DRAIN.
- **`inst_valid`**: high only in HOLD; `if_*` is stable while `inst_valid & !inst_ready`.
- **Back-to-back**: handshake and accept in the same cycle are both honoured; there is no bubble cycle on the AXI side beyond the state change.
- **`full` = 1 in HOLD**: the held instruction is still delivered on `inst_ready`; only new accepts are blocked.
- **`flush` and `pc_valid` in the same cycle**: no accept, since `pc_ready` = 0.

## Test plan
- **Aligned fetch, zero-wait slave.** Stimulus: reset released, `pc` = 0xBFC0_0000 valid, `arready`/`rvalid` immediate, `rdata` = 0x3C08_0001, `inst_ready` = 1. Required: `araddr` = 0xBFC0_0000 with `arlen` 0 and `arsize` 2; `inst_valid` 3 cycles after accept with `if_inst` = 0x3C08_0001 and `if_excepttype` = 0.
- **Backpressure.** Stimulus: `inst_ready` = 0 for 4 cycles after `inst_valid`. Required: `if_pc`/`if_inst` stable; `pc_ready` = 0; no new `arvalid`; one transfer when `inst_ready` rises.
- **Flush in ADDR, slave delay.** Stimulus: `flush` pulsed while `arvalid` is high, `arready` delayed 3 cycles. Required: `arvalid` held until `arready`; beat `rdata` = 0xDEAD_BEEF accepted and discarded; `inst_valid` never asserted; return to IDLE.
- **Misaligned fetch.** Stimulus: `pc` = 0x8000_0002. Required: no `arvalid`; `inst_valid` the next cycle with `if_inst` = 0 and `if_excepttype` = 0x0000_4000.
- **Bus error.** Stimulus: `rresp` = 2'b10. Required: `if_inst` = 0 and `if_excepttype` = 0x0000_2000.
- **Full and reset.** Stimulus: `full` = 1 in IDLE, then `rst` = 0 in DATA. Required: `pc_ready` = 0 while `full`; after reset all outputs 0 and state IDLE.
